// File: rtl/sync_fire_sched_if.sv
// rtl/sync_fire_sched_if.sv - signal bundle between gate-level model and firing scheduler
interface sync_fire_sched_if #(
    parameter int N  = 8,
    parameter int IW = $clog2(N),
    parameter int CW = 16
);
    logic          en;
    logic [N-1:0]  precap;
    logic [N-1:0]  state;
    logic [IW-1:0] ext_sel;
    logic [N-1:0]  fire_onehot;
    logic [IW-1:0] fire_idx;
    logic          fire_valid;
    logic          quiescent;
    logic          hazard;
    logic [IW-1:0] hazard_idx;
    logic [CW-1:0] fire_count;

    modport master (
        output en, precap, state, ext_sel,
        input  fire_onehot, fire_idx, fire_valid, quiescent, hazard, hazard_idx, fire_count
    );

    modport slave (
        input  en, precap, state, ext_sel,
        output fire_onehot, fire_idx, fire_valid, quiescent, hazard, hazard_idx, fire_count
    );
endinterface

// File: rtl/sync_fire_sched.sv
// rtl/sync_fire_sched.sv - excitation-aware single-fire scheduler with hazard detection
module sync_fire_sched #(
    parameter int          N         = 8,
    parameter int          IW        = $clog2(N),
    parameter int          MODE      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CW        = 16
) (
    input logic            clk,
    input logic            reset,
    sync_fire_sched_if.slave bus
);
    localparam logic [IW:0]   N_EXT = (IW+1)'(N);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);

    logic [N-1:0]  excited;
    logic [IW-1:0] ptr;
    logic [15:0]   lfsr;
    logic [N-1:0]  pexc;
    logic [N-1:0]  pfire;
    logic          hazard_q;
    logic [IW-1:0] hazard_idx_q;
    logic [CW-1:0] count_q;

    logic [IW-1:0] start;
    logic [IW:0]   cand;
    logic          found;
    logic [IW-1:0] sel_idx;
    logic          fire;
    logic [N-1:0]  onehot;
    logic [N-1:0]  viol;
    logic [IW-1:0] viol_idx;

    assign excited = bus.precap ^ bus.state;

    // Scan origin: pointer for round-robin, low LFSR bits (if in range) for random.
    always_comb begin
        start = '0;
        if (MODE == 0) begin
            start = ptr;
        end else if (MODE == 1) begin
            if ({1'b0, lfsr[IW-1:0]} < N_EXT)
                start = lfsr[IW-1:0];
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        if (MODE == 2) begin
            if (({1'b0, bus.ext_sel} < N_EXT) && excited[bus.ext_sel]) begin
                found   = 1'b1;
                sel_idx = bus.ext_sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, start} + (IW+1)'(k);
                if (cand >= N_EXT)
                    cand = cand - N_EXT;
                if (!found && excited[cand[IW-1:0]]) begin
                    found   = 1'b1;
                    sel_idx = cand[IW-1:0];
                end
            end
        end
    end

    // Reset gating keeps the capture enables dead while reset is held.
    assign fire   = reset & bus.en & found;
    assign onehot = fire ? (N'(1) << sel_idx) : '0;

    assign viol = pexc & ~pfire & ~excited;

    always_comb begin
        viol_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (viol[i])
                viol_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            lfsr         <= LFSR_SEED;
            pexc         <= '0;
            pfire        <= '0;
            hazard_q     <= 1'b0;
            hazard_idx_q <= '0;
            count_q      <= '0;
        end else if (bus.en) begin
            pexc  <= excited;
            pfire <= onehot;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (MODE == 0 && fire)
                ptr <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
            if (!hazard_q && |viol) begin
                hazard_q     <= 1'b1;
                hazard_idx_q <= viol_idx;
            end
            if (fire && count_q != {CW{1'b1}})
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.fire_onehot = onehot;
    assign bus.fire_idx    = fire ? sel_idx : '0;
    assign bus.fire_valid  = fire;
    assign bus.quiescent   = ~|excited;
    assign bus.hazard      = hazard_q;
    assign bus.hazard_idx  = hazard_idx_q;
    assign bus.fire_count  = count_q;
endmodule
